// File: rtl/io_fifo_port.sv
// io_fifo_port: core req/ack port bridging 16-bit TX and RX FIFOs to a device stream.
// Optional read-stall timeout enabled by defining IO_FIFO_PORT_TIMEOUT_EN.
`default_nettype none
module io_fifo_port #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_read,
  input  logic                   io_write,
  input  logic [15:0]            io_wdata,
  output logic                   ioack,
  output logic [15:0]            io_rdata,
  output logic [15:0]            tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [15:0]            rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("io_fifo_port: DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("io_fifo_port: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, DROP = 2'd2} state_e;

  state_e        state_q, state_d;
  logic          ioack_q;
  logic [15:0]   rdata_q, rdata_d;
  logic [15:0]   tx_mem_q [DEPTH];
  logic [15:0]   rx_mem_q [DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [LW-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          tx_full, rx_empty, to_fire;

  assign tx_full  = (tx_level_q == FULL);
  assign rx_empty = (rx_level_q == '0);
  assign tx_valid = (tx_level_q != '0);
  assign rx_ready = (rx_level_q != FULL);
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && rx_ready;

  assign ioack    = ioack_q;
  assign io_rdata = rdata_q;
  assign tx_data  = tx_mem_q[tx_rptr_q];
  assign tx_level = tx_level_q;
  assign rx_level = rx_level_q;

`ifdef IO_FIFO_PORT_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           read_stall;

  // Counts only while an otherwise-unserviceable read waits in IDLE.
  assign read_stall = (state_q == IDLE) && io_read && !io_write && rx_empty;
  assign to_fire    = read_stall && (to_cnt_q == TO_LAST);
  assign to_cnt_d   = (read_stall && !to_fire) ? to_cnt_q + TCW'(1) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        // A pending write always wins over a simultaneous read.
        if (io_write) begin
          if (!tx_full) begin
            tx_push = 1'b1;
            state_d = ACK;
          end
        end else if (io_read) begin
          if (!rx_empty) begin
            rx_pop  = 1'b1;
            rdata_d = rx_mem_q[rx_rptr_q];
            state_d = ACK;
          end else if (to_fire) begin
            rdata_d = '0;
            state_d = ACK;
          end
        end
      end
      ACK:     state_d = DROP;
      DROP:    if (!io_read && !io_write) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_level_d = tx_level_q;
    rx_level_d = rx_level_q;
    if (tx_push && !tx_pop)      tx_level_d = tx_level_q + LW'(1);
    else if (!tx_push && tx_pop) tx_level_d = tx_level_q - LW'(1);
    if (rx_push && !rx_pop)      rx_level_d = rx_level_q + LW'(1);
    else if (!rx_push && rx_pop) rx_level_d = rx_level_q - LW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ioack_q    <= 1'b0;
      rdata_q    <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_level_q <= '0;
      rx_level_q <= '0;
    end else begin
      state_q    <= state_d;
      ioack_q    <= (state_q == ACK);
      rdata_q    <= rdata_d;
      tx_level_q <= tx_level_d;
      rx_level_q <= rx_level_d;
      if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
      if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
    end
  end

  // Storage needs no reset: the pointers and levels define what is valid.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= io_wdata;
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
  end
endmodule
`default_nettype wire

// File: tb/tb_io_fifo_port.sv
// tb_io_fifo_port: randomized and directed checks of io_fifo_port against a queue-based model.
`default_nettype none
module tb_io_fifo_port;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clock = 1'b0, reset = 1'b1;
  logic        io_read = 1'b0, io_write = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [15:0] io_wdata = '0, rx_data = '0;
  logic        ioack, tx_valid, rx_ready;
  logic [15:0] io_rdata, tx_data;
  logic [2:0]  tx_level, rx_level;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_tx[$];
  logic [15:0] m_rx[$];
  logic [15:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  int          m_stage = 0;   // 0 idle, 1 acknowledging, 2 waiting for request drop
  int          m_cnt = 0;

  io_fifo_port #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .io_read(io_read), .io_write(io_write),
    .io_wdata(io_wdata), .ioack(ioack), .io_rdata(io_rdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_level(tx_level), .rx_level(rx_level)
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    m_tx.delete(); m_rx.delete();
    m_rdata = '0; m_ack = 1'b0; m_stage = 0; m_cnt = 0;
  endtask

  // Advance one clock from a falling edge, updating the model from pre-edge state.
  task automatic step();
    int tx_n, rx_n;
    bit acc_w, acc_r, acc_t;
    tx_n = m_tx.size(); rx_n = m_rx.size();
    acc_w = 0; acc_r = 0; acc_t = 0;
    if (m_stage == 0) begin
      if (io_write && tx_n < DEPTH) acc_w = 1;
      else if (!io_write && io_read && rx_n > 0) acc_r = 1;
    end
`ifdef IO_FIFO_PORT_TIMEOUT_EN
    if (m_stage == 0 && !io_write && io_read && rx_n == 0) begin
      if (m_cnt == TIMEOUT - 1) begin acc_t = 1; m_cnt = 0; end
      else m_cnt++;
    end else m_cnt = 0;
`endif
    if (tx_n > 0 && tx_ready) void'(m_tx.pop_front());
    if (acc_w) m_tx.push_back(io_wdata);
    if (acc_r) m_rdata = m_rx.pop_front();
    if (acc_t) m_rdata = '0;
    if (rx_valid && rx_n < DEPTH) m_rx.push_back(rx_data);
    m_ack = (m_stage == 1);
    if (m_stage == 1) m_stage = 2;
    else if (m_stage == 2 && !io_read && !io_write) m_stage = 0;
    if (acc_w || acc_r || acc_t) m_stage = 1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; io_read = 0; io_write = 0; tx_ready = 0; rx_valid = 0;
    model_clear();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic push_rx(input logic [15:0] d);
    rx_valid = 1'b1; rx_data = d;
    step();
    rx_valid = 1'b0;
  endtask

  // Core-side driver: holds the request until ioack, then drops it; lat is cycles to ioack or -1.
  task automatic core_xfer(input bit w, input bit r, input logic [15:0] d, input int budget,
                           output int lat, output int nack);
    io_write = w; io_read = r; io_wdata = d; lat = -1; nack = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (ioack === 1'b1) begin
        if (lat < 0) lat = k + 1;
        nack++;
        io_write = 0; io_read = 0;
      end else if (lat >= 0) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; #2; reset = 1'b0; #1;
    total++; if (ioack !== 1'b0) begin bad++; $display("FAIL rst_ioack: got %b want 0", ioack); end
    total++; if (io_rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0000", io_rdata); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_txvalid: got %b want 0", tx_valid); end
    total++; if (tx_level !== 3'd0) begin bad++; $display("FAIL rst_txlevel: got %0d want 0", tx_level); end
    total++; if (rx_level !== 3'd0) begin bad++; $display("FAIL rst_rxlevel: got %0d want 0", rx_level); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rst_rxready: got %b want 1", rx_ready); end
    @(negedge clock); @(negedge clock);
    reset = 1'b1; model_clear();
  endtask

  task automatic test_write_seq();
    int lat, nack;
    do_reset(); tx_ready = 0;
    core_xfer(1, 0, 16'h1234, 20, lat, nack);
    total++; if (lat !== 2 || nack !== 1) begin bad++; $display("FAIL wr1_ack: lat=%0d pulses=%0d want 2/1", lat, nack); end
    core_xfer(1, 0, 16'hABCD, 20, lat, nack);
    total++; if (lat !== 2 || nack !== 1) begin bad++; $display("FAIL wr2_ack: lat=%0d pulses=%0d want 2/1", lat, nack); end
    total++; if (tx_level !== 3'd2 || tx_data !== 16'h1234) begin bad++; $display("FAIL wr_fifo: level=%0d data=%h want 2/1234", tx_level, tx_data); end
    tx_ready = 1;
    step();
    total++; if (tx_data !== 16'hABCD || tx_level !== 3'd1) begin bad++; $display("FAIL wr_pop1: data=%h level=%0d want abcd/1", tx_data, tx_level); end
    step();
    total++; if (tx_valid !== 1'b0 || tx_level !== 3'd0) begin bad++; $display("FAIL wr_drain: valid=%b level=%0d want 0/0", tx_valid, tx_level); end
    tx_ready = 0;
  endtask

  task automatic test_full_stall();
    int lat, nack;
    logic [15:0] w [4];
    do_reset(); tx_ready = 0;
    for (int i = 0; i < 4; i++) begin
      w[i] = 16'($urandom);
      core_xfer(1, 0, w[i], 20, lat, nack);
    end
    total++; if (tx_level !== 3'd4) begin bad++; $display("FAIL full_level: got %0d want 4", tx_level); end
    io_write = 1; io_wdata = 16'h5A5A;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (ioack !== 1'b0 || tx_level !== 3'd4) begin bad++; $display("FAIL full_stall: ioack=%b level=%0d want 0/4", ioack, tx_level); end
    end
    tx_ready = 1; step(); tx_ready = 0;
    total++; if (ioack !== 1'b0 || tx_level !== 3'd3) begin bad++; $display("FAIL full_pop: ioack=%b level=%0d want 0/3", ioack, tx_level); end
    step();
    total++; if (ioack !== 1'b0 || tx_level !== 3'd4) begin bad++; $display("FAIL full_accept: ioack=%b level=%0d want 0/4", ioack, tx_level); end
    step();
    total++; if (ioack !== 1'b1) begin bad++; $display("FAIL full_ack: got %b want 1", ioack); end
    io_write = 0; step();
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      total++; if (tx_data !== ((i < 3) ? w[i+1] : 16'h5A5A)) begin bad++; $display("FAIL full_order%0d: got %h want %h", i, tx_data, (i < 3) ? w[i+1] : 16'h5A5A); end
      step();
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL full_empty: got %b want 0", tx_valid); end
    tx_ready = 0;
  endtask

  task automatic test_read_path();
    int lat, nack;
    do_reset();
    push_rx(16'h00FF);
    total++; if (rx_level !== 3'd1) begin bad++; $display("FAIL rd_push: level=%0d want 1", rx_level); end
    io_read = 1; step();
    total++; if (io_rdata !== 16'h00FF || rx_level !== 3'd0) begin bad++; $display("FAIL rd_load: data=%h level=%0d want 00ff/0", io_rdata, rx_level); end
    step();
    total++; if (ioack !== 1'b1) begin bad++; $display("FAIL rd_ack: got %b want 1", ioack); end
    push_rx(16'h0A0A); step(); step();
    total++; if (ioack !== 1'b0 || rx_level !== 3'd1 || io_rdata !== 16'h00FF) begin bad++; $display("FAIL rd_drop: ioack=%b level=%0d data=%h want 0/1/00ff", ioack, rx_level, io_rdata); end
    io_read = 0; step();
    core_xfer(0, 1, 16'h0, 20, lat, nack);
    total++; if (lat !== 2 || io_rdata !== 16'h0A0A || rx_level !== 3'd0) begin bad++; $display("FAIL rd_second: lat=%0d data=%h level=%0d want 2/0a0a/0", lat, io_rdata, rx_level); end
  endtask

  task automatic test_simultaneous();
    int lat, nack;
    logic [15:0] d [4];
    do_reset(); tx_ready = 0;
    for (int i = 0; i < 4; i++) begin d[i] = 16'($urandom); push_rx(d[i]); end
    total++; if (rx_level !== 3'd4 || rx_ready !== 1'b0) begin bad++; $display("FAIL sim_full: level=%0d ready=%b want 4/0", rx_level, rx_ready); end
    rx_valid = 1; rx_data = 16'hBEEF; io_read = 1;
    step(); rx_valid = 0;
    total++; if (rx_level !== 3'd3 || rx_ready !== 1'b1 || io_rdata !== d[0]) begin bad++; $display("FAIL sim_rdpush: level=%0d ready=%b data=%h want 3/1/%h", rx_level, rx_ready, io_rdata, d[0]); end
    step(); io_read = 0; step();
    for (int i = 1; i < 4; i++) begin
      core_xfer(0, 1, 16'h0, 20, lat, nack);
      total++; if (lat !== 2 || io_rdata !== d[i]) begin bad++; $display("FAIL sim_drain%0d: lat=%0d data=%h want 2/%h", i, lat, io_rdata, d[i]); end
    end
    total++; if (rx_level !== 3'd0) begin bad++; $display("FAIL sim_nobeef: level=%0d want 0", rx_level); end
    push_rx(16'h4321);
    io_write = 1; io_read = 1; io_wdata = 16'h8765;
    step();
    total++; if (tx_level !== 3'd1 || rx_level !== 3'd1 || tx_data !== 16'h8765) begin bad++; $display("FAIL sim_wrfirst: tx=%0d rx=%0d data=%h want 1/1/8765", tx_level, rx_level, tx_data); end
    step();
    total++; if (ioack !== 1'b1) begin bad++; $display("FAIL sim_ack: got %b want 1", ioack); end
    io_write = 0; io_read = 0; step();
    core_xfer(0, 1, 16'h0, 20, lat, nack);
    total++; if (lat !== 2 || io_rdata !== 16'h4321) begin bad++; $display("FAIL sim_rdafter: lat=%0d data=%h want 2/4321", lat, io_rdata); end
  endtask

  task automatic test_mid_reset();
    int lat, nack;
    do_reset(); tx_ready = 0;
    push_rx(16'hC0DE); push_rx(16'hFACE); push_rx(16'h0BAD);
    core_xfer(0, 1, 16'h0, 20, lat, nack);
    core_xfer(1, 0, 16'h2222, 20, lat, nack);
    io_write = 1; io_wdata = 16'h3333;
    step(); step();
    total++; if (ioack !== 1'b1 || tx_level !== 3'd2 || rx_level !== 3'd2) begin bad++; $display("FAIL mrst_pre: ioack=%b tx=%0d rx=%0d want 1/2/2", ioack, tx_level, rx_level); end
    #1 reset = 1'b0; io_write = 0;
    #1;
    total++; if (ioack !== 1'b0 || tx_level !== 3'd0 || rx_level !== 3'd0) begin bad++; $display("FAIL mrst_clear: ioack=%b tx=%0d rx=%0d want 0/0/0", ioack, tx_level, rx_level); end
    total++; if (io_rdata !== 16'h0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("FAIL mrst_out: data=%h valid=%b ready=%b want 0000/0/1", io_rdata, tx_valid, rx_ready); end
    model_clear();
    @(negedge clock); reset = 1'b1;
    core_xfer(1, 0, 16'h7777, 20, lat, nack);
    total++; if (lat !== 2 || tx_level !== 3'd1 || tx_data !== 16'h7777) begin bad++; $display("FAIL mrst_after_wr: lat=%0d tx=%0d data=%h want 2/1/7777", lat, tx_level, tx_data); end
    push_rx(16'h5151);
    core_xfer(0, 1, 16'h0, 20, lat, nack);
    total++; if (lat !== 2 || io_rdata !== 16'h5151) begin bad++; $display("FAIL mrst_after_rd: lat=%0d data=%h want 2/5151", lat, io_rdata); end
  endtask

  task automatic test_timeout();
    int lat, nack;
    do_reset();
    push_rx(16'h9999);
    core_xfer(0, 1, 16'h0, 20, lat, nack);
`ifdef IO_FIFO_PORT_TIMEOUT_EN
    core_xfer(0, 1, 16'h0, 50, lat, nack);
    total++; if (lat !== TIMEOUT + 1 || nack !== 1 || io_rdata !== 16'h0) begin bad++; $display("FAIL to_fire: lat=%0d pulses=%0d data=%h want %0d/1/0000", lat, nack, io_rdata, TIMEOUT + 1); end
    io_read = 1;
    repeat (5) step();
    io_read = 0; step();
    core_xfer(0, 1, 16'h0, 50, lat, nack);
    total++; if (lat !== TIMEOUT + 1) begin bad++; $display("FAIL to_clear: lat=%0d want %0d", lat, TIMEOUT + 1); end
`else
    core_xfer(0, 1, 16'h0, 1000, lat, nack);
    total++; if (lat !== -1 || nack !== 0 || io_rdata !== 16'h9999) begin bad++; $display("FAIL to_none: lat=%0d pulses=%0d data=%h want -1/0/9999", lat, nack, io_rdata); end
    push_rx(16'h6161); step(); step();
    total++; if (ioack !== 1'b1 || io_rdata !== 16'h6161) begin bad++; $display("FAIL to_late: ioack=%b data=%h want 1/6161", ioack, io_rdata); end
    io_read = 0; step();
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 16'($urandom);
      if (m_stage == 0 && !io_read && !io_write && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       io_write = 1;
          1:       io_read = 1;
          default: begin io_write = 1; io_read = 1; end
        endcase
        io_wdata = 16'($urandom);
      end
      if (m_tx.size() > 0) begin
        total++; if (tx_data !== m_tx[0]) begin bad++; $display("FAIL rnd_txdata c=%0d: got %h want %h", c, tx_data, m_tx[0]); end
      end
      step();
      total++; if (ioack !== m_ack) begin bad++; $display("FAIL rnd_ioack c=%0d: got %b want %b", c, ioack, m_ack); end
      total++; if (io_rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, io_rdata, m_rdata); end
      total++; if (tx_level !== m_tx.size() || rx_level !== m_rx.size()) begin bad++; $display("FAIL rnd_level c=%0d: tx=%0d rx=%0d want %0d/%0d", c, tx_level, rx_level, m_tx.size(), m_rx.size()); end
      total++; if (tx_valid !== (m_tx.size() > 0) || rx_ready !== (m_rx.size() < DEPTH)) begin bad++; $display("FAIL rnd_flags c=%0d: valid=%b ready=%b", c, tx_valid, rx_ready); end
      if (ioack === 1'b1) begin io_read = 0; io_write = 0; end
    end
    io_read = 0; io_write = 0; rx_valid = 0; tx_ready = 0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_write_seq();
    test_full_stall();
    test_read_path();
    test_simultaneous();
    test_mid_reset();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/io_fifo_port.md
IO_FIFO_PORT -- requirements
Module: io_fifo_port

Interface
REQ-001 Parameter DEPTH, default 4: entries per FIFO; must be a power of two and at least 2.
REQ-002 Parameter TIMEOUT, default 256: read-stall limit in cycles; used only when IO_FIFO_PORT_TIMEOUT_EN is defined.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 io_read  input  1  core read request; held high until acknowledged.
REQ-006 io_write  input  1  core write request; held high until acknowledged.
REQ-007 io_wdata  input  16  core write data (core DR), valid while io_write is high.
REQ-008 ioack  output  1  registered one-cycle acknowledge to the core.
REQ-009 io_rdata  output  16  registered read data returned to the core.
REQ-010 tx_data  output  16  head of the TX FIFO, going to the device.
REQ-011 tx_valid  output  1  TX FIFO is non-empty.
REQ-012 tx_ready  input  1  device accepts tx_data.
REQ-013 rx_data  input  16  data from the device.
REQ-014 rx_valid  input  1  rx_data is valid.
REQ-015 rx_ready  output  1  RX FIFO is not full.
REQ-016 tx_level, rx_level  output  log2(DEPTH)+1  registered occupancy counts, range 0..DEPTH.

Function
REQ-017 The handshake FSM SHALL have three states:
  - IDLE: waits for and services a request.
  - ACK: drives ioack=1 for exactly one cycle, then moves to DROP.
  - DROP: waits until io_read=0 and io_write=0, then returns to IDLE.
REQ-018 In IDLE, a write SHALL be serviced as follows:
  - io_write=1 and tx_level<DEPTH at an edge: push io_wdata into the TX FIFO and go to ACK.
  - TX FIFO full: stay in IDLE; the core stalls.
REQ-019 In IDLE, a read SHALL be serviced as follows:
  - io_read=1 and rx_level>0 at an edge: load io_rdata with the RX head, pop the RX FIFO and go to ACK.
  - RX FIFO empty: stay in IDLE; the core stalls.
REQ-020 If io_read and io_write are both high in IDLE, the write SHALL be serviced first; the read stays pending until the FSM returns to IDLE.
REQ-021 Latency SHALL be one cycle: a request accepted at edge N produces ioack=1 from edge N+1 to edge N+2.
REQ-022 io_rdata SHALL hold its value until the next serviced read.
REQ-023 The TX FIFO SHALL pop at every edge where tx_valid and tx_ready are both high.
  - tx_data SHALL always equal the head entry.
  - tx_data is don't-care when the FIFO is empty.
REQ-024 The RX FIFO SHALL push rx_data at every edge where rx_valid and rx_ready are both high.
REQ-025 Full and empty SHALL be judged on pre-edge levels.
  - Push and pop at the same edge SHALL leave the level unchanged.
  - A push into a full FIFO SHALL be refused even if a pop occurs at the same edge.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strictly first-in first-out.

Reset
REQ-027 reset=0 SHALL immediately, with no clock required, force:
  - the FSM to IDLE;
  - both FIFOs to empty with pointers at 0;
  - ioack=0, io_rdata=16'h0000, tx_valid=0, tx_level=0, rx_level=0;
  - the timeout counter to 0.
  rx_ready SHALL read 1 during reset.
REQ-028 Reset asserted mid-handshake SHALL abandon the transaction; FIFO contents SHALL be discarded.

Configuration
REQ-029 With IO_FIFO_PORT_TIMEOUT_EN defined, the read-stall counter SHALL behave as follows:
  - It counts consecutive IDLE cycles with io_read=1 and the RX FIFO empty.
  - When the count reaches TIMEOUT, the block SHALL load io_rdata=16'h0000, go to ACK without popping, and clear the counter.
  - The counter SHALL also clear on any serviced request or when io_read=0.
REQ-030 Without IO_FIFO_PORT_TIMEOUT_EN, a read on an empty RX FIFO SHALL stall indefinitely, and no counter logic SHALL exist.

Verification
REQ-031 Write sequence: with tx_ready=0, write 16'h1234 and then 16'hABCD, each with a full handshake.
  - Required: one ioack pulse per write, tx_level=2, tx_data=16'h1234.
  - Then raise tx_ready: the device receives 1234 then ABCD, tx_valid falls.
REQ-032 Full-FIFO stall: fill TX with 4 words, then hold a 5th write.
  - Required: ioack stays 0 while the FIFO is full.
  - One tx pop lets the write complete with ioack one cycle later; tx_level=4.
REQ-033 Read path: push 16'h00FF via rx_valid, then raise io_read.
  - Required: ioack high one cycle later, io_rdata=16'h00FF, rx_level=0.
  - The FSM stays in DROP until io_read falls.
REQ-034 Simultaneous events:
  - Full RX FIFO with rx_valid=1 and a core read at the same edge: level goes 4 to 3, no push is accepted, rx_ready=1 the next cycle.
  - io_read and io_write high together: the write is acknowledged first.
REQ-035 Mid-handshake reset: pulse reset low during ACK with both FIFOs non-empty.
  - Required: ioack=0, levels 0 and io_rdata=0 immediately; normal operation afterwards.
REQ-036 Timeout, with IO_FIFO_PORT_TIMEOUT_EN and TIMEOUT=8: read with RX empty.
  - Required: ioack after 8 stall cycles, io_rdata=16'h0000.
  - Without the macro: no ioack after 1000 cycles.
